// File: rtl/maze_pkg.sv
// Shared maze types: move encoding, replay FSM states and grid limits.
// Used by the replay player and by the solver's move translation.
package maze_pkg;

  localparam int COORD_W  = 4;
  localparam int GRID_MAX = 15;

  typedef enum logic [1:0] {
    MV_XP = 2'b00,
    MV_YP = 2'b01,
    MV_XN = 2'b10,
    MV_YN = 2'b11
  } move_t;

  typedef enum logic [2:0] {
    IDLE,
    EMIT,
    WAIT,
    FETCH,
    FINISH,
    ERROR
  } player_state_t;

endpackage

// File: rtl/maze_step_calc.sv
// Applies one move to an (x,y) position; combinational, zero latency, no handshake.
// oob flags a move leaving [0,MAXC]; the position is then passed through unchanged.
module maze_step_calc
  import maze_pkg::*;
#(
  parameter int W    = COORD_W,
  parameter int MAXC = GRID_MAX
) (
  input  logic [W-1:0] pos_x,
  input  logic [W-1:0] pos_y,
  input  move_t        move,
  output logic [W-1:0] new_x,
  output logic [W-1:0] new_y,
  output logic         oob
);

  localparam logic [W-1:0] MAX_C = W'(MAXC);

  always_comb begin
    new_x = pos_x;
    new_y = pos_y;
    oob   = 1'b0;
    case (move)
      MV_XP: if (pos_x >= MAX_C) oob = 1'b1; else new_x = pos_x + W'(1);
      MV_YP: if (pos_y >= MAX_C) oob = 1'b1; else new_y = pos_y + W'(1);
      MV_XN: if (pos_x == '0)    oob = 1'b1; else new_x = pos_x - W'(1);
      MV_YN: if (pos_y == '0)    oob = 1'b1; else new_y = pos_y - W'(1);
      default: oob = 1'b0;
    endcase
  end

endmodule

// File: rtl/maze_path_player.sv
// Replays the solved move queue as (x,y) positions; next position follows an accepted one by step_div+3 cycles.
// Position is held stable while pos_ready is low; nothing is popped from the queue until the handshake.
module maze_path_player #(
  parameter int COORD_W  = maze_pkg::COORD_W,
  parameter int GRID_MAX = maze_pkg::GRID_MAX,
  parameter int DIV_W    = 8,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               abort,
  input  logic [DIV_W-1:0]   step_div,
  input  logic               q_empty,
  input  logic [1:0]         q_data,
  output logic               dequeue,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               pos_valid,
  input  logic               pos_ready,
  output logic               busy,
  output logic               play_done,
  output logic               err_oob,
  output logic [CNT_W-1:0]   step_count
);

  import maze_pkg::*;

  player_state_t      state_q, state_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d;
  logic [COORD_W-1:0] pos_y_q, pos_y_d;
  logic [CNT_W-1:0]   step_count_q, step_count_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               err_oob_q, err_oob_d;
  logic               deq_req;

  logic [COORD_W-1:0] nxt_x, nxt_y;
  logic               step_oob;

  maze_step_calc #(
    .W    (COORD_W),
    .MAXC (GRID_MAX)
  ) u_step_calc (
    .pos_x (pos_x_q),
    .pos_y (pos_y_q),
    .move  (move_t'(q_data)),
    .new_x (nxt_x),
    .new_y (nxt_y),
    .oob   (step_oob)
  );

  always_comb begin
    state_d      = state_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    step_count_d = step_count_q;
    div_d        = div_q;
    err_oob_d    = err_oob_q;
    deq_req      = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            pos_x_d      = '0;
            pos_y_d      = '0;
            step_count_d = '0;
            err_oob_d    = 1'b0;
            state_d      = EMIT;
          end
        end
        EMIT: begin
          if (pos_ready) begin
            div_d   = step_div;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (div_q == '0) state_d = FETCH;
          else             div_d   = div_q - DIV_W'(1);
        end
        FETCH: begin
          if (q_empty) begin
            state_d = FINISH;
          end else if (step_oob) begin
            err_oob_d = 1'b1;
            state_d   = ERROR;
          end else begin
            deq_req = 1'b1;
            pos_x_d = nxt_x;
            pos_y_d = nxt_y;
            if (step_count_q != '1) step_count_d = step_count_q + CNT_W'(1);
            state_d = EMIT;
          end
        end
        FINISH:  state_d = IDLE;
        ERROR:   state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      step_count_q <= '0;
      div_q        <= '0;
      err_oob_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      step_count_q <= step_count_d;
      div_q        <= div_d;
      err_oob_q    <= err_oob_d;
    end
  end

  // Pop is suppressed during reset so the queue never loses a move the player discards.
  assign dequeue    = deq_req & rst;
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign pos_valid  = (state_q == EMIT);
  assign busy       = (state_q != IDLE);
  assign play_done  = (state_q == FINISH);
  assign err_oob    = err_oob_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_maze_path_player.sv
// Randomized replay bench for maze_path_player with a queue/arithmetic reference model.
module tb_maze_path_player;

  import maze_pkg::*;

  localparam int CW = 4;
  localparam int DW = 8;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] step_div = '0;
  logic          q_empty = 1'b1;
  logic [1:0]    q_data = '0;
  logic          pos_ready = 1'b0;
  logic          dequeue, pos_valid, busy, play_done, err_oob;
  logic [CW-1:0] pos_x, pos_y;
  logic [NW-1:0] step_count;

  always #5 clk = ~clk;

  maze_path_player #(
    .COORD_W (CW),
    .GRID_MAX(15),
    .DIV_W   (DW),
    .CNT_W   (NW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .abort     (abort),
    .step_div  (step_div),
    .q_empty   (q_empty),
    .q_data    (q_data),
    .dequeue   (dequeue),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .pos_valid (pos_valid),
    .pos_ready (pos_ready),
    .busy      (busy),
    .play_done (play_done),
    .err_oob   (err_oob),
    .step_count(step_count)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  bit         pend_pop = 1'b0;
  logic [1:0] mq[$];
  logic [1:0] scen[$];
  int         exp_x[$];
  int         exp_y[$];
  int         n_ok;
  bit         exp_oob;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  function automatic int dx(input logic [1:0] m);
    return (m == 2'b00) ? 1 : (m == 2'b10) ? -1 : 0;
  endfunction

  function automatic int dy(input logic [1:0] m);
    return (m == 2'b01) ? 1 : (m == 2'b11) ? -1 : 0;
  endfunction

  function automatic bit off_grid(input int x, input int y);
    return (x < 0) || (x > GRID_MAX) || (y < 0) || (y > GRID_MAX);
  endfunction

  // Expected emissions: (0,0) then one position per legal move, stopping at the first illegal one.
  function automatic void build_model();
    int  x = 0;
    int  y = 0;
    bit  stop = 1'b0;
    exp_x.delete();
    exp_y.delete();
    exp_x.push_back(0);
    exp_y.push_back(0);
    n_ok    = 0;
    exp_oob = 1'b0;
    foreach (scen[i]) begin
      if (!stop) begin
        if (off_grid(x + dx(scen[i]), y + dy(scen[i]))) begin
          exp_oob = 1'b1;
          stop    = 1'b1;
        end else begin
          x = x + dx(scen[i]);
          y = y + dy(scen[i]);
          exp_x.push_back(x);
          exp_y.push_back(y);
          n_ok++;
        end
      end
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (pend_pop && mq.size() > 0) void'(mq.pop_front());
    pend_pop = 1'b0;
    q_empty  = (mq.size() == 0);
    q_data   = q_empty ? 2'b00 : mq[0];
  endtask

  task automatic settle();
    #1;
    pend_pop = dequeue;
  endtask

  task automatic gen_walk(input int len, input bit want_oob);
    int x = 0;
    int y = 0;
    scen.delete();
    for (int i = 0; i < len; i++) begin
      logic [1:0] m;
      m = 2'($urandom_range(3));
      if (off_grid(x + dx(m), y + dy(m))) m = (x < GRID_MAX) ? 2'b00 : 2'b10;
      x = x + dx(m);
      y = y + dy(m);
      scen.push_back(m);
    end
    if (want_oob) begin
      for (int i = 0; i <= x; i++) scen.push_back(2'b10);
      scen.push_back(2'b01);
    end
  endtask

  task automatic run_replay(input int sd_lo, input int sd_hi, input int rdy_pct);
    int            hs = 0;
    int            deq = 0;
    int            last_hs = 0;
    int            last_sd = 0;
    int            run_cyc = 0;
    bit            prev_v = 1'b0;
    bit            hold = 1'b0;
    bit            fin = 1'b0;
    bit            done_seen = 1'b0;
    logic [CW-1:0] hx = '0;
    logic [CW-1:0] hy = '0;
    build_model();
    mq = scen;
    for (int t = 0; t < 3000 && !fin; t++) begin
      tick();
      run       = (t == 0);
      pos_ready = ($urandom_range(99) < rdy_pct);
      step_div  = DW'($urandom_range(sd_hi, sd_lo));
      settle();
      if (t == 0) run_cyc = cyc;
      if (t == 1) chk("oob_clear_on_run", 32'(err_oob), 0);
      if (hold) begin
        chk("bp_valid", 32'(pos_valid), 1);
        chk("bp_x", 32'(pos_x), 32'(hx));
        chk("bp_y", 32'(pos_y), 32'(hy));
      end
      if (pos_valid && !prev_v)
        chk("emit_latency", 32'(cyc - ((hs == 0) ? run_cyc : last_hs)),
            32'((hs == 0) ? 1 : last_sd + 3));
      if (pos_valid && pos_ready) begin
        if (hs < exp_x.size()) begin
          chk("pos_x", 32'(pos_x), 32'(exp_x[hs]));
          chk("pos_y", 32'(pos_y), 32'(exp_y[hs]));
        end else begin
          chk("extra_emit", 32'(hs), 32'(exp_x.size()));
        end
        hs++;
        last_hs = cyc;
        last_sd = int'(step_div);
      end
      hold = pos_valid && !pos_ready;
      hx   = pos_x;
      hy   = pos_y;
      if (dequeue) begin
        chk("deq_while_empty", 32'(q_empty), 0);
        deq++;
      end
      if (play_done) begin
        chk("done_latency", 32'(cyc - last_hs), 32'(last_sd + 3));
        done_seen = 1'b1;
        fin       = 1'b1;
      end
      if (t > 1 && err_oob) begin
        chk("oob_latency", 32'(cyc - last_hs), 32'(last_sd + 3));
        fin = 1'b1;
      end
      prev_v = pos_valid;
    end
    run = 1'b0;
    chk("replay_timeout", 32'(fin), 1);
    chk("emit_count", 32'(hs), 32'(exp_x.size()));
    chk("dequeue_count", 32'(deq), 32'(n_ok));
    chk("step_count", 32'(step_count), 32'(n_ok));
    chk("err_oob", 32'(err_oob), 32'(exp_oob));
    chk("play_done_seen", 32'(done_seen), 32'(!exp_oob));
    if (exp_oob) begin
      tick(); run = 1'b1; settle();
      chk("err_run_ignored", 32'(busy), 1);
      chk("err_no_deq", 32'(dequeue), 0);
      chk("err_pos_x", 32'(pos_x), 32'(exp_x[exp_x.size()-1]));
      chk("err_pos_y", 32'(pos_y), 32'(exp_y[exp_y.size()-1]));
      tick(); run = 1'b0; abort = 1'b1; settle();
      tick(); abort = 1'b0; settle();
      chk("abort_idle", 32'(busy), 0);
      chk("abort_keeps_oob", 32'(err_oob), 1);
    end else begin
      tick(); settle();
      chk("idle_after_done", 32'(busy), 0);
      chk("done_one_cycle", 32'(play_done), 0);
    end
    if (!fin) begin
      tick(); abort = 1'b1; settle();
      tick(); abort = 1'b0; settle();
    end
  endtask

  task automatic reset_mid_wait();
    int hs = 0;
    bit hit = 1'b0;
    scen = '{2'b00, 2'b01, 2'b00};
    mq   = scen;
    tick(); run = 1'b1; pos_ready = 1'b1; step_div = DW'(4); settle();
    for (int t = 0; t < 100 && !hit; t++) begin
      tick();
      run = 1'b0;
      if (hs == 2) begin
        chk("pre_rst_steps", 32'(step_count), 1);
        rst = 1'b0;
        hit = 1'b1;
      end
      settle();
      if (pos_valid && pos_ready) hs++;
    end
    tick(); rst = 1'b1; settle();
    chk("rst_reached_wait", 32'(hit), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(pos_valid), 0);
    chk("rst_pos_x", 32'(pos_x), 0);
    chk("rst_pos_y", 32'(pos_y), 0);
    chk("rst_steps", 32'(step_count), 0);
    chk("rst_deq", 32'(dequeue), 0);
    chk("rst_done", 32'(play_done), 0);
  endtask

  task automatic abort_mid_emit();
    int hs = 0;
    bit hit = 1'b0;
    scen = '{2'b00, 2'b00};
    mq   = scen;
    tick(); run = 1'b1; pos_ready = 1'b1; step_div = '0; settle();
    for (int t = 0; t < 100 && !hit; t++) begin
      tick();
      run       = 1'b0;
      pos_ready = (hs == 0);
      settle();
      if (pos_valid && pos_ready) hs++;
      else if (hs == 1 && pos_valid) hit = 1'b1;
    end
    tick(); abort = 1'b1; pos_ready = 1'b0; settle();
    tick(); abort = 1'b0; settle();
    chk("abort_reached_emit", 32'(hit), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(pos_valid), 0);
    chk("abort_pos_x", 32'(pos_x), 1);
    chk("abort_pos_y", 32'(pos_y), 0);
    chk("abort_steps", 32'(step_count), 1);
    chk("abort_deq", 32'(dequeue), 0);
  endtask

  initial begin
    repeat (3) begin tick(); settle(); end
    chk("reset_valid", 32'(pos_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_deq", 32'(dequeue), 0);
    chk("reset_done", 32'(play_done), 0);
    chk("reset_oob", 32'(err_oob), 0);
    chk("reset_pos", 32'({pos_x, pos_y}), 0);
    chk("reset_steps", 32'(step_count), 0);
    tick(); rst = 1'b1; settle();

    scen = '{2'b00, 2'b00, 2'b01, 2'b01};
    run_replay(0, 0, 100);
    scen = '{2'b00};
    run_replay(3, 3, 100);
    scen = '{2'b00, 2'b01};
    run_replay(0, 2, 30);
    scen = '{2'b10, 2'b00};
    run_replay(0, 1, 100);
    scen.delete();
    run_replay(0, 0, 100);
    reset_mid_wait();
    abort_mid_emit();

    for (int s = 0; s < 25; s++) begin
      gen_walk($urandom_range(12), $urandom_range(3) == 0);
      run_replay(0, $urandom_range(4), $urandom_range(100, 30));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/maze_path_player.md
Name: maze_path_player

Overview:
- Replay controller for the solved rat-in-maze path.
- Once the solver has filled the move queue, this block drains the queue one move at a time at a programmable pace.
- For each move it rebuilds the rat's (x,y) position and presents it over a valid/ready handshake to a display or trace consumer.
- It sits between the move queue (dequeue side) and the display logic, and replaces the bare "run/dequeue until empty" sequencing.

Parameters:
- COORD_W, 4, width of x/y coordinates.
- GRID_MAX, 15, largest legal coordinate on either axis.
- DIV_W, 8, width of the step-pacing divider.
- CNT_W, 8, width of the replayed-step counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- run  in  1  start replay; sampled only in IDLE.
- abort  in  1  cancel replay; highest priority after reset.
- step_div  in  DIV_W  idle cycles inserted between moves; sampled at each handshake.
- q_empty  in  1  move queue empty.
- q_data  in  2  head-of-queue move, first-word-fall-through, valid when q_empty=0.
- dequeue  out  1  one-cycle pop strobe to the queue.
- pos_x  out  COORD_W  current x.
- pos_y  out  COORD_W  current y.
- pos_valid  out  1  position offered to the consumer.
- pos_ready  in  1  consumer accepts.
- busy  out  1  high in any state except IDLE.
- play_done  out  1  one-cycle pulse when the queue has been fully replayed.
- err_oob  out  1  sticky flag: a move would leave the grid.
- step_count  out  CNT_W  moves applied since the last run; saturates at all-ones.

Behaviour:
- Move encoding:
  - 00: x+1
  - 01: y+1
  - 10: x-1
  - 11: y-1
- Reset (rst=0 at an edge): state IDLE. pos_x, pos_y, step_count and the divider count all 0. dequeue, pos_valid, play_done and err_oob all 0.
- Otherwise, when abort=1: next state IDLE, no dequeue, pos and step_count hold, err_oob holds.
- State IDLE:
  - If run=1: clear pos and step_count to 0, clear err_oob, go to EMIT.
- State EMIT:
  - pos_valid=1.
  - pos_x and pos_y are stable while pos_valid=1 and pos_ready=0.
  - On pos_valid & pos_ready: load the divider with step_div, go to WAIT.
- State WAIT:
  - If the divider is 0, go to FETCH; otherwise decrement it.
  - WAIT therefore lasts step_div+1 cycles.
- State FETCH:
  - If q_empty=1: go to FINISH.
  - Else if applying q_data would make a coordinate <0 or >GRID_MAX: set err_oob, go to ERROR. No dequeue, pos unchanged.
  - Else: dequeue=1 for exactly this cycle. pos updates at the same edge. step_count increments, saturating. Go to EMIT.
- State FINISH:
  - play_done=1 for one cycle, then IDLE.
- State ERROR:
  - Hold until abort or reset.
  - run is ignored.
- Latency:
  - run sampled at edge k gives pos_valid=1 in cycle k+1, showing (0,0).
  - A handshake at edge h gives the next pos_valid in cycle h+step_div+3, or play_done in that cycle if the queue is empty.
- dequeue is never asserted when q_empty=1, and never more than once per handshake.
- The initial (0,0) emission does not count as a step.
- run arriving while busy=1 is ignored.
- If pos_ready is held high permanently, the block paces purely by step_div.

Decomposition:
- Shared package maze_pkg holds:
  - move_t enum (MV_XP=2'b00, MV_YP, MV_XN, MV_YN)
  - player_state_t enum (IDLE, EMIT, WAIT, FETCH, FINISH, ERROR)
  - COORD_W and GRID_MAX constants
- One sub-module, maze_step_calc: combinational. Takes pos and move; returns new pos and an oob flag. It is reusable by the solver's move translation.
- Divider and step counter stay inline.

Test Plan:
1. Queue holds 00,00,01,01, with step_div=0 and pos_ready=1. Response:
   - pos_valid sequence (0,0),(1,0),(2,0),(2,1),(2,2).
   - Four dequeue pulses.
   - play_done one cycle after the last FETCH sees q_empty.
   - step_count=4.
2. step_div=3, pos_ready=1, queue 00. Response:
   - (0,0) valid in the cycle after run.
   - (1,0) valid exactly 6 cycles after the first handshake edge.
3. Backpressure: pos_ready=0 for 5 cycles on (1,0). Response:
   - pos_valid stays 1 and pos stays (1,0).
   - No dequeue until the handshake occurs.
4. Queue holds 10 at start. Response:
   - err_oob=1 in the state after FETCH.
   - No dequeue, pos stays (0,0), run ignored.
   - abort returns to IDLE with err_oob still 1.
   - The next run clears it.
5. Empty queue on run. Response:
   - (0,0) emitted.
   - After the handshake and 1 WAIT cycle (step_div=0): play_done pulse, step_count=0, no dequeue.
6. Mid-replay: rst=0 for one cycle during WAIT, and separately abort during EMIT. Response:
   - Reset: all outputs are at reset values next cycle.
   - Abort: IDLE next cycle, pos held, no dequeue, busy=0.
